// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTYPE  = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_IMMEX  = 4'd9,
      S_JUMP   = 4'd10,
      S_HALT   = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic       IORD_PC     = 1'b0;
   localparam logic       IORD_ALUOUT = 1'b1;
   localparam logic [1:0] REGDST_RT   = 2'd0;
   localparam logic [1:0] REGDST_RD   = 2'd1;
   localparam logic [1:0] REGDST_RA   = 2'd2;
   localparam logic [1:0] M2R_ALUOUT  = 2'd0;
   localparam logic [1:0] M2R_MDR     = 2'd1;
   localparam logic [1:0] M2R_PC      = 2'd2;
   localparam logic       SRCA_PC     = 1'b0;
   localparam logic       SRCA_A      = 1'b1;
   localparam logic [1:0] SRCB_B      = 2'd0;
   localparam logic [1:0] SRCB_FOUR   = 2'd1;
   localparam logic [1:0] SRCB_IMM    = 2'd2;
   localparam logic [1:0] SRCB_IMMSH  = 2'd3;
   localparam logic [1:0] PCSRC_ALU   = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP  = 2'd2;

   function automatic logic is_imm_op(input logic [5:0] op);
      return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
   endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Selects the ALU operation from FSM state, opcode and funct; combinational.
// funct_valid flags whether funct names a supported R-type operation.
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [2:0] alu_ctrl,
   output logic       funct_valid
);

   logic [2:0] fn_ctrl;
   logic [2:0] imm_ctrl;

   always_comb begin
      fn_ctrl     = ALU_ADD;
      funct_valid = 1'b1;
      case (funct)
         FN_ADD, FN_ADDU: fn_ctrl = ALU_ADD;
         FN_SUB:          fn_ctrl = ALU_SUB;
         FN_AND:          fn_ctrl = ALU_AND;
         FN_OR:           fn_ctrl = ALU_OR;
         FN_SLT:          fn_ctrl = ALU_SLT;
         default:         funct_valid = 1'b0;
      endcase
   end

   always_comb begin
      imm_ctrl = ALU_ADD;
      case (opcode)
         OP_ANDI: imm_ctrl = ALU_AND;
         OP_ORI:  imm_ctrl = ALU_OR;
         OP_SLTI: imm_ctrl = ALU_SLT;
         default: imm_ctrl = ALU_ADD;
      endcase
   end

   // Every state not listed uses the adder (PC+4, branch target, address calc).
   always_comb begin
      alu_ctrl = ALU_ADD;
      case (state)
         S_RTYPE:  alu_ctrl = fn_ctrl;
         S_IMMEX:  alu_ctrl = imm_ctrl;
         S_BRANCH: alu_ctrl = ALU_SUB;
         default:  alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch/decode/execute/memory/writeback.
// Strobes decode the current state in-cycle (some follow mem_ready/zero); state, illegal, retired are registered.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter logic [5:0] HALT_OPCODE = 6'h3F,
   parameter bit         WAIT_EN     = 1'b1,
   parameter int         CNT_W       = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_ctrl,
   output logic [1:0]       pc_source,
   output logic [3:0]       state,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t cur;
   logic   rdy;
   logic   retire;
   logic   funct_valid;

   assign rdy = WAIT_EN ? mem_ready : 1'b1;

   mips_alu_decoder u_alu_dec (
      .state       (cur),
      .opcode      (opcode),
      .funct       (funct),
      .alu_ctrl    (alu_ctrl),
      .funct_valid (funct_valid)
   );

   always_comb begin
      retire = 1'b0;
      case (cur)
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: retire = 1'b1;
         S_MEMWR:                            retire = rdy;
         default:                            retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur     <= S_FETCH;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (retire)
            retired <= retired + 1'b1;
         case (cur)
            S_FETCH:  if (rdy) cur <= S_DECODE;
            S_DECODE: begin
               if (opcode == HALT_OPCODE) begin
                  cur <= S_HALT;
               end else begin
                  case (opcode)
                     OP_RTYPE:                         cur <= S_RTYPE;
                     OP_LW, OP_SW:                     cur <= S_MEMADR;
                     OP_BEQ, OP_BNE:                   cur <= S_BRANCH;
                     OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: cur <= S_IMMEX;
                     OP_J, OP_JAL:                     cur <= S_JUMP;
                     default: begin
                        illegal <= 1'b1;
                        cur     <= S_FETCH;
                     end
                  endcase
               end
            end
            S_MEMADR: cur <= (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (rdy) cur <= S_MEMWB;
            S_MEMWB:  cur <= S_FETCH;
            S_MEMWR:  if (rdy) cur <= S_FETCH;
            S_RTYPE: begin
               if (funct_valid) begin
                  cur <= S_ALUWB;
               end else begin
                  illegal <= 1'b1;
                  cur     <= S_FETCH;
               end
            end
            S_IMMEX:  cur <= S_ALUWB;
            S_ALUWB, S_BRANCH, S_JUMP: cur <= S_FETCH;
            S_HALT:   cur <= S_HALT;
            default:  cur <= S_FETCH;
         endcase
      end
   end

   // Outputs are forced quiet while rst_n is low so an access in flight is dropped at once.
   always_comb begin
      pc_en      = 1'b0;
      iord       = IORD_PC;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = REGDST_RT;
      mem_to_reg = M2R_ALUOUT;
      reg_write  = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_B;
      pc_source  = PCSRC_ALU;
      if (rst_n) begin
         case (cur)
            S_FETCH: begin
               mem_read  = 1'b1;
               ir_write  = rdy;
               pc_en     = rdy;
               alu_src_b = SRCB_FOUR;
            end
            S_DECODE: alu_src_b = SRCB_IMMSH;
            S_MEMADR: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
               mem_read = 1'b1;
               iord     = IORD_ALUOUT;
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = M2R_MDR;
            end
            S_MEMWR: begin
               mem_write = 1'b1;
               iord      = IORD_ALUOUT;
            end
            S_RTYPE: alu_src_a = SRCA_A;
            S_ALUWB: begin
               reg_write = 1'b1;
               reg_dst   = is_imm_op(opcode) ? REGDST_RT : REGDST_RD;
            end
            S_BRANCH: begin
               alu_src_a = SRCA_A;
               pc_source = PCSRC_ALUOUT;
               pc_en     = (opcode == OP_BEQ) ? zero : !zero;
            end
            S_IMMEX: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
            end
            S_JUMP: begin
               pc_source = PCSRC_JUMP;
               pc_en     = 1'b1;
               if (opcode == OP_JAL) begin
                  reg_write  = 1'b1;
                  reg_dst    = REGDST_RA;
                  mem_to_reg = M2R_PC;
               end
            end
            default: ;
         endcase
      end
   end

   assign state  = cur;
   assign halted = (cur == S_HALT);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-cycle expectations queued as stimulus is driven,
// popped and compared at the falling edge.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
   logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
   logic [2:0]  alu_ctrl;
   logic [3:0]  state;
   logic        halted, illegal;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mips_multicycle_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_ctrl   (alu_ctrl),
      .pc_source  (pc_source),
      .state      (state),
      .halted     (halted),
      .illegal    (illegal),
      .retired    (retired)
   );

   typedef struct packed {
      logic [3:0]  st;
      logic [17:0] ctl;
      logic        hlt;
      logic        ill;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_step  = 0;
   logic [31:0] exp_ret;
   logic        exp_ill;

   localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

   // {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source}
   function automatic logic [17:0] c(input logic pe, input logic io, input logic rd, input logic wr,
                                     input logic irw, input logic [1:0] rdst, input logic [1:0] m2r,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [2:0] alu, input logic [1:0] pcs);
      return {pe, io, rd, wr, irw, rdst, m2r, rw, asa, asb, alu, pcs};
   endfunction

   localparam logic [17:0] QUIET    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] FET_RDY  = c(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, ADD, 2'd0);
   localparam logic [17:0] FET_WAIT = c(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, ADD, 2'd0);
   localparam logic [17:0] DEC      = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, ADD, 2'd0);
   localparam logic [17:0] MADR     = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, ADD, 2'd0);
   localparam logic [17:0] MRD      = c(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] MWB      = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] MWR      = c(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] AWB_R    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] AWB_I    = c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, ADD, 2'd0);
   localparam logic [17:0] JMP      = c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, ADD, 2'd2);
   localparam logic [17:0] JAL      = c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, ADD, 2'd2);

   function automatic logic [17:0] rt(input logic [2:0] alu);
      return c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, alu, 2'd0);
   endfunction

   function automatic logic [17:0] imm(input logic [2:0] alu);
      return c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, alu, 2'd0);
   endfunction

   function automatic logic [17:0] br(input logic pe);
      return c(pe, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, SUB, 2'd1);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s step %0d: got %0h, expected %0h", tag, n_step, got, want);
      end
   endtask

   // One cycle: drive inputs, queue expectation, compare at negedge, advance past posedge.
   task automatic step(input logic rdy, input logic z, input logic [3:0] st, input logic [17:0] ctl,
                       input logic ret, input logic ill_set);
      exp_t e;
      mem_ready = rdy;
      zero      = z;
      e.st  = st;
      e.ctl = ctl;
      e.hlt = (st == 4'd11);
      e.ill = exp_ill;
      e.ret = exp_ret;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check("state",   32'(state), 32'(e.st));
      check("ctl",     32'({pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                            reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source}), 32'(e.ctl));
      check("halted",  32'(halted),  32'(e.hlt));
      check("illegal", 32'(illegal), 32'(e.ill));
      check("retired", retired, e.ret);
      @(posedge clk);
      #1;
      n_step++;
      if (ret)     exp_ret = exp_ret + 32'd1;
      if (ill_set) exp_ill = 1'b1;
   endtask

   task automatic run_lw();
      opcode = 6'h23;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd2, MADR,    1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd3, MRD,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd4, MWB,     1'b1, 1'b0);
   endtask

   task automatic run_branch(input logic [5:0] op, input logic z, input logic taken);
      opcode = op;
      step(1'b1, z, 4'd0, FET_RDY,   1'b0, 1'b0);
      step(1'b1, z, 4'd1, DEC,       1'b0, 1'b0);
      step(1'b1, z, 4'd8, br(taken), 1'b1, 1'b0);
   endtask

   task automatic run_rtype(input logic [5:0] fn, input logic [2:0] alu);
      opcode = 6'h00;
      funct  = fn;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd6, rt(alu), 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd7, AWB_R,   1'b1, 1'b0);
   endtask

   task automatic run_imm(input logic [5:0] op, input logic [2:0] alu);
      opcode = op;
      step(1'b0, 1'b0, 4'd0, FET_WAIT, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd0, FET_RDY,  1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,      1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd9, imm(alu), 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd7, AWB_I,    1'b1, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'h00;
      funct     = 6'h00;
      zero      = 1'b0;
      mem_ready = 1'b1;
      exp_ret   = 32'd0;
      exp_ill   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step(1'b1, 1'b0, 4'd0, QUIET, 1'b0, 1'b0);
      rst_n = 1'b1;

      run_lw();

      // sw with three not-ready cycles in MEMWR
      opcode = 6'h2B;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd2, MADR,    1'b0, 1'b0);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b0, 4'd5, MWR, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd5, MWR, 1'b1, 1'b0);

      run_branch(6'h04, 1'b1, 1'b1);
      run_branch(6'h05, 1'b1, 1'b0);
      run_branch(6'h04, 1'b0, 1'b0);
      run_branch(6'h05, 1'b0, 1'b1);

      run_rtype(6'h2A, SLT);
      run_rtype(6'h22, SUB);
      run_rtype(6'h25, OR_);
      run_rtype(6'h24, AND_);

      // unsupported funct: flagged, no writeback, not retired
      opcode = 6'h00;
      funct  = 6'h3F;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd6, rt(ADD), 1'b0, 1'b1);

      run_imm(6'h08, ADD);
      run_imm(6'h0D, OR_);
      run_imm(6'h0A, SLT);

      // undecodable opcode
      opcode = 6'h3E;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b1);

      opcode = 6'h02;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd10, JMP,    1'b1, 1'b0);

      // reset while a load waits in MEMRD
      opcode = 6'h23;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd2, MADR,    1'b0, 1'b0);
      step(1'b0, 1'b0, 4'd3, MRD,     1'b0, 1'b0);
      rst_n   = 1'b0;
      exp_ret = 32'd0;
      exp_ill = 1'b0;
      step(1'b0, 1'b0, 4'd0, QUIET, 1'b0, 1'b0);
      rst_n = 1'b1;
      run_lw();

      opcode = 6'h03;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd10, JAL,    1'b1, 1'b0);

      opcode = 6'h3F;
      step(1'b1, 1'b0, 4'd0, FET_RDY, 1'b0, 1'b0);
      step(1'b1, 1'b0, 4'd1, DEC,     1'b0, 1'b0);
      for (int i = 0; i < 100; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'd11, QUIET, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multicycle variant of the MIPS core.
- Sequences the shared memory port, PC, instruction register, register file and ALU across fetch, decode, execute, memory and writeback cycles.
- Sits beside the datapath and drives its control signals. Honours a memory ready handshake. Reports halt and the retired-instruction count to the testbench.

Parameters:
- HALT_OPCODE, 6'h3F, opcode that enters HALT.
- WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored (single-cycle memory).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC load enable (write or taken branch).
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  2  writeback register: 0 = rt, 1 = rd, 2 = $ra.
- mem_to_reg  out  2  writeback data: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2.
- alu_ctrl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- state  out  4  current state, debug.
- halted  out  1  in HALT.
- illegal  out  1  sticky: an undecodable instruction was seen.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n low): state = FETCH.
  - All strobes/enables = 0; all muxes = 0; alu_ctrl = 010.
  - halted = 0, illegal = 0, retired = 0.
- Outputs are a Moore decode of state (and opcode/funct/zero where noted). They are valid in the same cycle as the state.

States and transitions:
- FETCH(0): mem_read, iord = 0, ir_write = mem_ready, alu_src_a = 0, alu_src_b = 1, add, pc_source = 0, pc_en = mem_ready.
  - Stay while !mem_ready (WAIT_EN = 1), then go to DECODE.
  - PC and IR update only on the ready cycle.
- DECODE(1): alu_src_a = 0, alu_src_b = 3, add (branch target into ALUOut). Next state by opcode:
  - 6'h00 → RTYPE.
  - 6'h23/6'h2B → MEMADR.
  - 6'h04/6'h05 → BRANCH.
  - 6'h08/0C/0D/0A → IMMEX.
  - 6'h02/6'h03 → JUMP.
  - HALT_OPCODE → HALT.
  - Any other → set illegal, go to FETCH (treated as nop, not retired).
- MEMADR(2): alu_src_a = 1, alu_src_b = 2, add. lw → MEMRD, sw → MEMWR.
- MEMRD(3): mem_read, iord = 1. Hold until mem_ready, then MEMWB.
- MEMWB(4): reg_write, reg_dst = 0, mem_to_reg = 1. Retire, then FETCH.
- MEMWR(5): mem_write, iord = 1.
  - mem_write stays asserted while waiting.
  - On mem_ready: retire, then FETCH.
- RTYPE(6): alu_src_a = 1, alu_src_b = 0. alu_ctrl from funct:
  - 20/21 → add; 22 → sub; 24 → and; 25 → or; 2A → slt.
  - Other funct: set illegal, go to FETCH without writeback.
  - Valid funct → ALUWB.
- ALUWB(7): reg_write, mem_to_reg = 0. reg_dst = 1 for R-type, 0 for immediate. Retire, then FETCH.
- BRANCH(8): alu_src_a = 1, alu_src_b = 0, sub, pc_source = 1.
  - pc_en = zero for beq, !zero for bne.
  - Retire, then FETCH.
- IMMEX(9): alu_src_a = 1, alu_src_b = 2. alu_ctrl by opcode:
  - 08 → add; 0C → and; 0D → or; 0A → slt.
  - Then ALUWB.
  - Zero-extension of andi/ori is the datapath's job.
- JUMP(10): pc_source = 2, pc_en.
  - jal also asserts reg_write, reg_dst = 2, mem_to_reg = 2; PC is already PC+4 at this point.
  - Retire, then FETCH.
- HALT(11): all strobes 0, halted = 1. Absorbing; exits only via reset.

Latency (mem_ready always 1):
- lw 5 cycles.
- sw, R-type, immediate ops 4 cycles.
- beq/bne, j/jal 3 cycles.
- Each wait cycle adds 1.

Counter and reset rules:
- retired increments exactly once on each retiring cycle and wraps modulo 2^CNT_W.
- It is not incremented for illegal instructions or HALT.
- Reset mid-access drops the strobes immediately; there is no pending write-back.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings;
  - opcode constants (RTYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, SLTI, J, JAL);
  - funct constants;
  - alu_ctrl codes;
  - mux select codes.
- One sub-module, mips_alu_decoder: combinational (state, opcode, funct) → alu_ctrl, funct_valid.

Test Plan:
- Reset release, mem_ready = 1, lw (opcode 23) → states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; retired=1 after 5 cycles.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write high for 4 consecutive cycles; retired increments only on the ready cycle.
- beq with zero=1 → pc_en=1, pc_source=1 in BRANCH; bne with zero=1 → pc_en=0; each takes 3 cycles.
- R-type funct 2A → alu_ctrl=111 in RTYPE, reg_dst=1 in ALUWB; funct 3F → illegal=1, no reg_write, back to FETCH, retired unchanged.
- jal → JUMP asserts pc_en, reg_write, reg_dst=2, mem_to_reg=2; then opcode 3F → halted=1, state 11 held for 100 cycles with no strobes.
- rst_n pulsed low during MEMRD → outputs clear asynchronously, state=0, retired=0; after release the next fetch proceeds normally.
